// File: rtl/gpr_write_arbiter_pkg.sv
// Shared processing-unit types for the GPR write path.
package Pu_types;

  localparam int GPR_COUNT = 32;

  typedef logic [4:0]  Reg_index;
  typedef logic [31:0] Word;

  typedef struct packed {
    Reg_index sel;
    Word      data;
  } Gpr_wr_req;

endpackage

// File: rtl/gpr_wr_slot.sv
// One-entry holding buffer for a single result source, stamped with its arrival cycle.
module gpr_wr_slot
  import Pu_types::*;
#(
  parameter int AGE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  output logic             ready,
  input  Gpr_wr_req        req,
  input  logic [AGE_W-1:0] counter,
  input  logic             grant,
  output logic             vld,
  output Gpr_wr_req        held,
  output logic [AGE_W-1:0] stamp
);

  // A granted buffer empties at this edge, so it can take a new write with no bubble.
  assign ready = !vld | grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld   <= 1'b0;
      held  <= '0;
      stamp <= '0;
    end else if (valid && ready) begin
      vld   <= 1'b1;
      held  <= req;
      stamp <= counter;
    end else if (grant) begin
      vld   <= 1'b0;
    end
  end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Merges buffered results from several execution units onto the single GPR write port,
// draining the oldest buffered write each cycle and exporting a pending-register mask.
module gpr_write_arbiter
  import Pu_types::*;
#(
  parameter int NUM_SRC = 3,
  parameter int AGE_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_valid,
  output logic [NUM_SRC-1:0]     src_ready,
  input  Reg_index [NUM_SRC-1:0] src_sel,
  input  Word [NUM_SRC-1:0]      src_data,
  output logic                   wa_wr,
  output Reg_index               wa_sel,
  output Word                    wa,
  output logic [GPR_COUNT-1:0]   pending
);

  logic [AGE_W-1:0] counter;
  logic [NUM_SRC-1:0] vld;
  logic [NUM_SRC-1:0] grant;
  Gpr_wr_req        held  [NUM_SRC];
  logic [AGE_W-1:0] stamp [NUM_SRC];
  logic [AGE_W-1:0] age   [NUM_SRC];
  logic [AGE_W-1:0] best_age;
  logic             found;

  always_ff @(posedge clk) begin
    if (reset) counter <= '0;
    else       counter <= counter + 1'b1;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    Gpr_wr_req req;
    assign req.sel  = src_sel[i];
    assign req.data = src_data[i];

    gpr_wr_slot #(.AGE_W(AGE_W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .valid   (src_valid[i]),
      .ready   (src_ready[i]),
      .req     (req),
      .counter (counter),
      .grant   (grant[i]),
      .vld     (vld[i]),
      .held    (held[i]),
      .stamp   (stamp[i])
    );
  end

  // Modular age survives counter wrap because waits never exceed NUM_SRC-1 cycles;
  // strict greater-than leaves same-cycle ties with the lowest index.
  always_comb begin
    grant    = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      age[i] = counter - stamp[i];
      if (vld[i] && (!found || age[i] > best_age)) begin
        found    = 1'b1;
        best_age = age[i];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign wa_wr = |vld;

  always_comb begin
    wa_sel  = '0;
    wa      = '0;
    pending = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        wa_sel = held[i].sel;
        wa     = held[i].data;
      end
      if (vld[i]) pending[held[i].sel] = 1'b1;
    end
  end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an arrival-order model.
module tb_gpr_write_arbiter;
  import Pu_types::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     src_valid;
  logic [2:0]     src_ready;
  Reg_index [2:0] src_sel;
  Word [2:0]      src_data;
  logic           wa_wr;
  Reg_index       wa_sel;
  Word            wa;
  logic [31:0]    pending;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  // model: each source buffer remembers its absolute arrival cycle
  bit       mVld  [3] = '{0, 0, 0};
  Reg_index mSel  [3] = '{0, 0, 0};
  Word      mData [3] = '{0, 0, 0};
  int       mArr  [3] = '{0, 0, 0};
  int       cycle = 0;
  Word      gprModel [32];
  Word      gprDut   [32];
  Word      saved;

  gpr_write_arbiter #(.NUM_SRC(3), .AGE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_sel   (src_sel),
    .src_data  (src_data),
    .wa_wr     (wa_wr),
    .wa_sel    (wa_sel),
    .wa        (wa),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelGrant();
    int best = -1;
    for (int i = 0; i < 3; i++)
      if (mVld[i] && (best < 0 || mArr[i] < mArr[best])) best = i;
    return best;
  endfunction

  // register file fed by the DUT write port
  always @(posedge clk) begin
    if (!reset && wa_wr) gprDut[wa_sel] <= wa;
  end

  // model advance: retire the oldest write, then accept offers into free or draining buffers
  always @(posedge clk) begin
    int g;
    bit rdy [3];
    if (reset) begin
      for (int i = 0; i < 3; i++) mVld[i] = 0;
    end else begin
      g = modelGrant();
      for (int i = 0; i < 3; i++) rdy[i] = !mVld[i] || (g == i);
      if (g >= 0) begin
        gprModel[mSel[g]] = mData[g];
        mVld[g] = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (src_valid[i] && rdy[i]) begin
          mVld[i]  = 1;
          mSel[i]  = src_sel[i];
          mData[i] = src_data[i];
          mArr[i]  = cycle;
        end
      end
    end
    cycle++;
  end

  // per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (checkEn) begin
      int g;
      logic [31:0] expPend;
      logic [2:0]  expRdy;
      g = modelGrant();
      expPend = '0;
      for (int i = 0; i < 3; i++) begin
        if (mVld[i]) expPend[mSel[i]] = 1'b1;
        expRdy[i] = !mVld[i] || (g == i);
      end
      checkOutput("model wa_wr", {31'b0, wa_wr}, {31'b0, g >= 0});
      checkOutput("model wa_sel", {27'b0, wa_sel}, (g >= 0) ? {27'b0, mSel[g]} : 32'h0);
      checkOutput("model wa", wa, (g >= 0) ? mData[g] : 32'h0);
      checkOutput("model pending", pending, expPend);
      checkOutput("model src_ready", {29'b0, src_ready}, {29'b0, expRdy});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v, input Reg_index s0, input Reg_index s1,
                               input Reg_index s2, input Word d0, input Word d1, input Word d2);
    src_valid   = v;
    src_sel[0]  = s0;
    src_sel[1]  = s1;
    src_sel[2]  = s2;
    src_data[0] = d0;
    src_data[1] = d1;
    src_data[2] = d2;
  endtask

  task automatic idle();
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " wa_wr"}, {31'b0, wa_wr}, 32'h0);
    checkOutput({tag, " wa_sel"}, {27'b0, wa_sel}, 32'h0);
    checkOutput({tag, " wa"}, wa, 32'h0);
    checkOutput({tag, " pending"}, pending, 32'h0);
    checkOutput({tag, " src_ready"}, {29'b0, src_ready}, 32'h7);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      gprModel[r] = '0;
      gprDut[r]   = '0;
    end
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset   = 1'b0;
    checkEn = 1;

    // reset release and one idle cycle
    checkQuiet("reset");
    tick();
    checkQuiet("idle");

    // single write from src1
    applyStimulus(3'b010, 0, 5, 0, 0, 32'hDEAD_BEEF, 0);
    tick();
    idle();
    checkOutput("single wa_wr", {31'b0, wa_wr}, 32'h1);
    checkOutput("single wa_sel", {27'b0, wa_sel}, 32'd5);
    checkOutput("single wa", wa, 32'hDEAD_BEEF);
    checkOutput("single pending", pending, 32'h20);
    tick();
    checkOutput("single drained wa_wr", {31'b0, wa_wr}, 32'h0);
    checkOutput("single drained pending", pending, 32'h0);

    // same-cycle contention retires lowest index first
    applyStimulus(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33);
    tick();
    idle();
    checkOutput("contend pending", pending, 32'h0000_000E);
    for (int k = 1; k <= 3; k++) begin
      checkOutput("contend wa_sel", {27'b0, wa_sel}, k);
      checkOutput("contend wa", wa, 32'h11 * k);
      tick();
    end
    checkOutput("contend done wa_wr", {31'b0, wa_wr}, 32'h0);

    // same-register ordering: older r7 value retires first, younger survives
    applyStimulus(3'b001, 9, 0, 0, 32'h99, 0, 0);
    tick();
    applyStimulus(3'b100, 0, 0, 7, 0, 0, 32'h1);
    checkOutput("order r9 first", {27'b0, wa_sel}, 32'd9);
    tick();
    applyStimulus(3'b001, 7, 0, 0, 32'h2, 0, 0);
    checkOutput("order first r7 sel", {27'b0, wa_sel}, 32'd7);
    checkOutput("order first r7 data", wa, 32'h1);
    tick();
    idle();
    checkOutput("order second r7 sel", {27'b0, wa_sel}, 32'd7);
    checkOutput("order second r7 data", wa, 32'h2);
    tick();
    checkOutput("order drained", {31'b0, wa_wr}, 32'h0);
    checkOutput("order gpr r7", gprDut[7], 32'h2);

    // 40-write stream from src0 crossing the stamp wrap
    applyStimulus(3'b001, 0, 0, 0, 32'h1000, 0, 0);
    tick();
    for (int k = 1; k < 40; k++) begin
      checkOutput("stream ready", {31'b0, src_ready[0]}, 32'h1);
      checkOutput("stream wa_wr", {31'b0, wa_wr}, 32'h1);
      checkOutput("stream wa", wa, 32'h1000 + k - 1);
      applyStimulus(3'b001, Reg_index'(k % 32), 0, 0, 32'h1000 + k, 0, 0);
      tick();
    end
    idle();
    checkOutput("stream last wa", wa, 32'h1000 + 39);
    tick();
    checkOutput("stream drained", {31'b0, wa_wr}, 32'h0);
    checkOutput("stream gpr r7", gprDut[7], 32'h1000 + 39);

    // reset with three buffers valid drops them all
    saved = gprDut[10];
    applyStimulus(3'b111, 10, 11, 12, 32'hA, 32'hB, 32'hC);
    tick();
    idle();
    checkOutput("midreset pending before", pending, 32'h0000_1C00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkQuiet("midreset");
    tick();
    checkOutput("midreset no write", {31'b0, wa_wr}, 32'h0);
    checkOutput("midreset gpr r10", gprDut[10], saved);
    checkOutput("midreset gpr r7", gprDut[7], 32'h1000 + 39);

    // random traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), Reg_index'($urandom_range(0, 7)),
                    Reg_index'($urandom_range(0, 7)), Reg_index'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    for (int n = 0; n < 6; n++) tick();
    for (int r = 0; r < 32; r++) checkOutput("final gpr", gprDut[r], gprModel[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
